// File: rtl/spk_out.sv
`default_nettype none
// ============================================================================
// Module      : spk_out
// Description : Transmit side of the node flit link. Packs soma spikes into
//               flits, merges them with pre-formatted config flits through a
//               round-robin ingress arbiter, buffers everything in a 2^B deep
//               FIFO and drains it under credit-based flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module spk_out #(
  parameter int B      = 4,
  parameter int FW     = 59,
  parameter int FTW    = 3,
  parameter int SW     = 24,
  parameter int CREDIT = 16
) (
  input  logic                  clk_spk_out,
  input  logic                  rst_n,
  // soma spike request
  input  logic                  soma_spk_out_vld,
  input  logic [FTW-1:0]        soma_spk_out_type,
  input  logic [SW-1:0]         soma_spk_out_data,
  output logic                  spk_out_soma_busy,
  // static destination field
  input  logic [FW-FTW-SW-1:0]  dst_addr,
  // config flit path
  input  logic                  config_spk_out_vld,
  input  logic [FW-1:0]         config_spk_out_data,
  output logic                  spk_out_config_credit,
  output logic                  spk_out_err,
  // link side
  output logic [FW-1:0]         flit_out,
  output logic                  flit_out_wr,
  input  logic                  credit_in
);

  localparam int            DEPTH      = 1 << B;
  localparam logic [B:0]    NEAR_FULL  = (B+1)'(DEPTH - 1);
  localparam logic [B:0]    CREDIT_MAX = (B+1)'(CREDIT);
  localparam logic [B:0]    CNT_ONE    = (B+1)'(1);
  localparam logic [B-1:0]  PTR_ONE    = B'(1);
  localparam logic [FTW-1:0] T_SPIKE    = FTW'(0);
  localparam logic [FTW-1:0] T_DATA     = FTW'(1);
  localparam logic [FTW-1:0] T_DATA_END = FTW'(2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [FW-1:0] mem_q [DEPTH];
  logic [B-1:0]  wr_ptr_q;
  logic [B-1:0]  rd_ptr_q;
  logic [B:0]    count_q;
  logic [B:0]    credit_q;
  logic [B:0]    credit_d;
  logic          rr_q;
  logic          rr_d;
  state_e        state_q;
  logic [FW-1:0] flit_q;
  logic          flit_wr_q;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic          near_full;
  logic          cfg_grant;
  logic          soma_grant;
  logic          soma_type_ok;
  logic          push;
  logic          pop;
  logic [FW-1:0] push_data;

  // Keep one slot of headroom so a push and pop in the same cycle can never
  // overflow, even when the egress side is stalled on credits.
  assign near_full = (count_q >= NEAR_FULL);

  assign soma_type_ok = (soma_spk_out_type == T_SPIKE) ||
                        (soma_spk_out_type == T_DATA)  ||
                        (soma_spk_out_type == T_DATA_END);

  // Ingress arbiter: single requester wins outright, contested cycles
  // alternate using rr_q (0 favours config, 1 favours soma).
  always_comb begin
    cfg_grant  = 1'b0;
    soma_grant = 1'b0;
    rr_d       = rr_q;
    if (rst_n && !near_full) begin
      if (config_spk_out_vld && soma_spk_out_vld) begin
        if (rr_q == 1'b0) begin
          cfg_grant = 1'b1;
        end else begin
          soma_grant = 1'b1;
        end
        rr_d = ~rr_q;
      end else if (config_spk_out_vld) begin
        cfg_grant = 1'b1;
      end else if (soma_spk_out_vld) begin
        soma_grant = 1'b1;
      end
    end
  end

  // An illegal soma type still consumes its grant, but nothing is queued.
  assign push      = cfg_grant | (soma_grant & soma_type_ok);
  assign push_data = cfg_grant ? config_spk_out_data
                               : {soma_spk_out_type, dst_addr, soma_spk_out_data};

  // The head entry leaves whenever there is both data and a downstream slot.
  assign pop = (count_q != '0) && (credit_q != '0);

  // Credit accounting: a returned credit and a pop in the same cycle cancel;
  // returns beyond the initial allowance are ignored.
  always_comb begin
    credit_d = credit_q;
    if (pop && !credit_in) begin
      credit_d = credit_q - CNT_ONE;
    end else if (!pop && credit_in && (credit_q != CREDIT_MAX)) begin
      credit_d = credit_q + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_spk_out) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers, occupancy and arbiter fairness pointer.
  always_ff @(posedge clk_spk_out) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      rr_q <= rr_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Egress state machine: loads flit_out on each pop and strobes it for the
  // following cycle; SEND persists while back-to-back pops are possible.
  always_ff @(posedge clk_spk_out) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      flit_q    <= '0;
      flit_wr_q <= 1'b0;
      credit_q  <= CREDIT_MAX;
    end else begin
      flit_wr_q <= 1'b0;
      credit_q  <= credit_d;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            flit_q    <= mem_q[rd_ptr_q];
            flit_wr_q <= 1'b1;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop) begin
            flit_q    <= mem_q[rd_ptr_q];
            flit_wr_q <= 1'b1;
            state_q   <= ST_SEND;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign spk_out_soma_busy     = near_full;
  assign spk_out_config_credit = cfg_grant;
  assign spk_out_err           = soma_grant & ~soma_type_ok;
  assign flit_out              = flit_q;
  assign flit_out_wr           = flit_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_spk_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_spk_out
// Description : Self-checking bench for spk_out: per-cycle vector table for
//               the single-flit, arbitration and error cases, followed by
//               hand-written sequences for credit stall, credit-coincident
//               streaming and mid-transfer reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spk_out;

  localparam logic [31:0] DST  = 32'h1;
  localparam logic [58:0] SPK1 = {3'b000, 32'h1, 24'h0A0B0C};
  localparam logic [58:0] SPK2 = {3'b001, 32'h1, 24'h123456};
  localparam logic [58:0] SPK3 = {3'b010, 32'h1, 24'hABCDEF};
  localparam logic [58:0] CFG1 = {3'b011, 56'hDEADBEEF012345};
  localparam logic [58:0] CFG2 = {3'b111, 56'h00C0FFEE00BEEF};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        soma_vld;
  logic [2:0]  soma_type;
  logic [23:0] soma_data;
  logic        busy;
  logic [31:0] dst_addr;
  logic        cfg_vld;
  logic [58:0] cfg_data;
  logic        cfg_credit;
  logic        err;
  logic [58:0] flit_out;
  logic        flit_out_wr;
  logic        credit_in;

  always #5 clk = ~clk;

  spk_out dut (
    .clk_spk_out           (clk),
    .rst_n                 (rst_n),
    .soma_spk_out_vld      (soma_vld),
    .soma_spk_out_type     (soma_type),
    .soma_spk_out_data     (soma_data),
    .spk_out_soma_busy     (busy),
    .dst_addr              (dst_addr),
    .config_spk_out_vld    (cfg_vld),
    .config_spk_out_data   (cfg_data),
    .spk_out_config_credit (cfg_credit),
    .spk_out_err           (err),
    .flit_out              (flit_out),
    .flit_out_wr           (flit_out_wr),
    .credit_in             (credit_in)
  );

  typedef struct {
    logic        s_vld;
    logic [2:0]  s_type;
    logic [23:0] s_data;
    logic        c_vld;
    logic [58:0] c_data;
    logic        e_busy;
    logic        e_cc;
    logic        e_err;
    logic        e_wr;
    logic [58:0] e_flit;
  } vec_t;

  vec_t        vecs[$];
  logic [58:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  logic        mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic sv, input logic [2:0] st, input logic [23:0] sd,
                               input logic cv, input logic [58:0] cd,
                               input logic ecc, input logic eerr, input logic ewr,
                               input logic [58:0] ef);
    vec_t v;
    v.s_vld = sv; v.s_type = st; v.s_data = sd;
    v.c_vld = cv; v.c_data = cd;
    v.e_busy = 1'b0; v.e_cc = ecc; v.e_err = eerr; v.e_wr = ewr; v.e_flit = ef;
    return v;
  endfunction

  // Egress scoreboard: every strobed flit must match the oldest accepted one.
  always @(negedge clk) begin
    if (mon_en && rst_n && flit_out_wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL flit_unexpected: got %0h expected no strobe", flit_out);
      end else begin
        chk("flit_order", {5'b0, flit_out}, {5'b0, exp_q.pop_front()});
      end
    end
  end

  // Offer one soma spike per cycle until `target` accepted or budget spent.
  task automatic offer_spikes(input int target, inout int acc);
    int cyc = 0;
    while (acc < target && cyc < 200) begin
      soma_vld  = 1'b1;
      soma_type = 3'b000;
      soma_data = 24'(acc);
      @(negedge clk);
      if (!busy) begin
        exp_q.push_back({3'b000, DST, 24'(acc)});
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    soma_vld = 1'b0;
    if (acc < target) chk("offer_timeout", 64'(acc), 64'(target));
  endtask

  initial begin
    int acc;
    int wr_base;
    rst_n = 1'b0; soma_vld = 1'b0; soma_type = '0; soma_data = '0;
    dst_addr = DST; cfg_vld = 1'b0; cfg_data = '0; credit_in = 1'b0;

    // -------- vector table --------
    // single spike
    vecs.push_back(mkv(1, 3'b000, 24'h0A0B0C, 0, '0, 0, 0, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 1, SPK1));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 0, '0));
    // contested: config, soma, config, soma
    vecs.push_back(mkv(1, 3'b001, 24'h123456, 1, CFG1, 1, 0, 0, '0));
    vecs.push_back(mkv(1, 3'b001, 24'h123456, 1, CFG1, 0, 0, 0, '0));
    vecs.push_back(mkv(1, 3'b001, 24'h123456, 1, CFG1, 1, 0, 1, CFG1));
    vecs.push_back(mkv(1, 3'b001, 24'h123456, 1, CFG1, 0, 0, 1, SPK2));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0,   0, 0, 1, CFG1));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0,   0, 0, 1, SPK2));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0,   0, 0, 0, '0));
    // illegal soma type: error pulse, nothing emitted
    vecs.push_back(mkv(1, 3'b110, 24'h777777, 0, '0, 0, 1, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 0, '0));
    // config flit passes unchanged regardless of its type field
    vecs.push_back(mkv(0, 3'b000, 24'h0, 1, CFG2, 1, 0, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0, 0, '0,   0, 0, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0, 0, '0,   0, 0, 1, CFG2));
    vecs.push_back(mkv(0, 3'b000, 24'h0, 0, '0,   0, 0, 0, '0));
    // DATA_END spike
    vecs.push_back(mkv(1, 3'b010, 24'hABCDEF, 0, '0, 0, 0, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 0, '0));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 1, SPK3));
    vecs.push_back(mkv(0, 3'b000, 24'h0,      0, '0, 0, 0, 0, '0));

    // -------- reset --------
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr",     64'(flit_out_wr), 64'd0);
    chk("rst_flit",   64'(flit_out), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_cc",     64'(cfg_credit), 64'd0);
    chk("rst_err",    64'(err), 64'd0);
    chk("rst_credit", 64'(dut.credit_q), 64'd16);
    chk("rst_count",  64'(dut.count_q), 64'd0);
    @(posedge clk); #1;

    // -------- table loop --------
    for (int i = 0; i < vecs.size(); i++) begin
      soma_vld = vecs[i].s_vld; soma_type = vecs[i].s_type; soma_data = vecs[i].s_data;
      cfg_vld  = vecs[i].c_vld; cfg_data  = vecs[i].c_data;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_cc", i),   64'(cfg_credit), 64'(vecs[i].e_cc));
      chk($sformatf("v%0d_err", i),  64'(err), 64'(vecs[i].e_err));
      chk($sformatf("v%0d_wr", i),   64'(flit_out_wr), 64'(vecs[i].e_wr));
      if (vecs[i].e_wr) chk($sformatf("v%0d_flit", i), 64'(flit_out), 64'(vecs[i].e_flit));
      if (i == 3) chk("t1_credit", 64'(dut.credit_q), 64'd15);
      @(posedge clk); #1;
    end
    soma_vld = 1'b0; cfg_vld = 1'b0;
    // 7 flits sent so far, the illegal request queued nothing
    chk("tbl_count",  64'(dut.count_q), 64'd0);
    chk("tbl_credit", 64'(dut.credit_q), 64'd9);

    // -------- credit saturation: 8 returns on 9 -> capped at 16 --------
    mon_en = 1'b1;
    repeat (8) begin credit_in = 1'b1; @(posedge clk); #1; end
    credit_in = 1'b0;
    chk("credit_sat", 64'(dut.credit_q), 64'd16);

    // -------- credit exhaustion with 20 spikes --------
    acc = 0;
    offer_spikes(20, acc);
    repeat (10) @(posedge clk); #1;
    chk("t3_wr16",    64'(wr_cnt), 64'd16);
    chk("t3_count4",  64'(dut.count_q), 64'd4);
    chk("t3_credit0", 64'(dut.credit_q), 64'd0);
    // fill to the busy threshold
    offer_spikes(31, acc);
    @(negedge clk);
    chk("t3_busy",    64'(busy), 64'd1);
    chk("t3_count15", 64'(dut.count_q), 64'd15);
    // a held request must not be accepted while busy
    @(posedge clk); #1;
    soma_vld = 1'b1; soma_type = 3'b000; soma_data = 24'hFFFFFF;
    repeat (3) @(posedge clk); #1;
    soma_vld = 1'b0;
    chk("t3_hold15",  64'(dut.count_q), 64'd15);
    // four returned credits release exactly four flits
    repeat (4) begin credit_in = 1'b1; @(posedge clk); #1; end
    credit_in = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("t3_wr20",    64'(wr_cnt), 64'd20);
    chk("t3_count11", 64'(dut.count_q), 64'd11);
    chk("t3_nobusy",  64'(busy), 64'd0);

    // -------- credit returned alongside every pop --------
    wr_base = wr_cnt;
    for (int k = 0; k < 32; k++) begin
      credit_in = 1'b1;
      soma_vld = 1'b1; soma_type = 3'b000; soma_data = 24'(acc);
      @(negedge clk);
      if (!busy) begin
        exp_q.push_back({3'b000, DST, 24'(acc)});
        acc++;
      end
      if (k >= 1) chk($sformatf("t4_credit_%0d", k), 64'(dut.credit_q), 64'd1);
      if (k >= 2) chk($sformatf("t4_wr_%0d", k), 64'(flit_out_wr), 64'd1);
      @(posedge clk); #1;
    end
    credit_in = 1'b0; soma_vld = 1'b0;
    chk("t4_flits30", 64'(wr_cnt - wr_base), 64'd30);
    repeat (3) @(posedge clk); #1;
    chk("t4_credit0", 64'(dut.credit_q), 64'd0);

    // -------- reset with flits queued --------
    credit_in = 1'b1; @(posedge clk); #1;
    credit_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_wr",     64'(flit_out_wr), 64'd0);
    chk("t6_count",  64'(dut.count_q), 64'd0);
    chk("t6_credit", 64'(dut.credit_q), 64'd16);
    wr_base = wr_cnt;
    repeat (5) @(posedge clk); #1;
    chk("t6_quiet",  64'(wr_cnt - wr_base), 64'd0);
    acc = 100;
    offer_spikes(101, acc);
    repeat (4) @(posedge clk); #1;
    chk("t6_newflit", 64'(wr_cnt - wr_base), 64'd1);
    chk("t6_credit15", 64'(dut.credit_q), 64'd15);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
